// File: rtl/jvm_operand_emitter_if.sv
// jvm_operand_emitter_if: fetch-side byte stream, writer-side instruction stream and status of the operand emitter.
interface jvm_operand_emitter_if;
    logic        start;
    logic [2:0]  op_count;
    logic        is_wide;
    logic        sign;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        busy;
    logic        done;
    logic        err;
    modport master (
        output start, op_count, is_wide, sign, in_byte, in_valid, inst_ready,
        input  in_ready, inst, inst_valid, busy, done, err
    );
    modport slave (
        input  start, op_count, is_wide, sign, in_byte, in_valid, inst_ready,
        output in_ready, inst, inst_valid, busy, done, err
    );
endinterface

// File: rtl/jvm_operand_emitter.sv
// jvm_operand_emitter: assembles up to MAX_BYTES big-endian operand bytes into Rn (MOV/LSL/ORR) and pushes it once.
// Macro SIGNEXT_EN adds an LSL/ASR pair that sign-extends 1..3 byte operands.
module jvm_operand_emitter #(
    parameter int MAX_BYTES  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int REG_NUM    = 0
) (
    input logic clk,
    input logic reset,
    jvm_operand_emitter_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] N = 32'(REG_NUM & 15);
`ifdef SIGNEXT_EN
    typedef enum logic [2:0] {S_IDLE, S_FIRST, S_SHIFT, S_MERGE, S_PUSH, S_SEXT_L, S_SEXT_A} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FIRST, S_SHIFT, S_MERGE, S_PUSH} state_t;
`endif
    state_t r_state, w_next, w_tail;
    logic [3:0] w_k, r_rem;
    logic w_bad, w_start, w_take, w_adv, w_full, w_pop, r_done, r_err;
    logic [31:0] w_inst;
    logic [31:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    assign w_k = 4'(bus.op_count) << bus.is_wide;
    assign w_bad = {28'd0, w_k} > 32'(MAX_BYTES);
    assign w_start = bus.start && r_state == S_IDLE;
    assign w_full = r_cnt == CW'(FIFO_DEPTH);
    assign w_pop = r_cnt != 0 && bus.inst_ready;
`ifdef SIGNEXT_EN
    logic r_sext;
    logic [4:0] r_s;
    assign w_tail = r_sext ? S_SEXT_L : S_PUSH;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sext <= 1'b0;
            r_s <= '0;
        end else if (w_start) begin
            r_sext <= bus.sign && w_k != 0 && w_k < 4;
            r_s <= 5'(6'd32 - {w_k[2:0], 3'b000});
        end
    end
`else
    logic w_unused_sign;
    assign w_unused_sign = bus.sign;
    assign w_tail = S_PUSH;
`endif
    always_ff @(posedge clk) r_state <= reset ? S_IDLE : w_next;
    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE) begin
            if (w_start && w_k != 0 && !w_bad) w_next = S_FIRST;
        end else if (w_adv) begin
            case (r_state)
                S_FIRST, S_MERGE: w_next = r_rem == 4'd1 ? w_tail : S_SHIFT;
                S_SHIFT:          w_next = S_MERGE;
`ifdef SIGNEXT_EN
                S_SEXT_L:         w_next = S_SEXT_A;
                S_SEXT_A:         w_next = S_PUSH;
`endif
                default:          w_next = S_IDLE;
            endcase
        end
    end
    always_comb begin
        w_take = r_state == S_FIRST || r_state == S_MERGE;
        w_adv = r_state != S_IDLE && !w_full && (!w_take || bus.in_valid);
        bus.in_ready = w_take && !w_full;
        bus.busy = r_state != S_IDLE || r_done;
        bus.done = r_done;
        bus.err = r_err;
        bus.inst_valid = r_cnt != 0;
        bus.inst = r_cnt != 0 ? r_mem[r_rp] : '0;
        case (r_state)
            S_FIRST:  w_inst = 32'hE3A00000 | N << 12 | {24'd0, bus.in_byte};
            S_SHIFT:  w_inst = 32'hE1A00400 | N << 12 | N;
            S_MERGE:  w_inst = 32'hE3800000 | N << 16 | N << 12 | {24'd0, bus.in_byte};
            S_PUSH:   w_inst = 32'hE52D0004 | N << 12;
`ifdef SIGNEXT_EN
            S_SEXT_L: w_inst = 32'hE1A00000 | N << 12 | {27'd0, r_s} << 7 | N;
            S_SEXT_A: w_inst = 32'hE1A00040 | N << 12 | {27'd0, r_s} << 7 | N;
`endif
            default:  w_inst = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem <= '0;
            r_done <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_done <= (r_state == S_PUSH && w_adv) || (w_start && w_k == 0);
            r_err <= w_start && w_bad;
            if (w_start) r_rem <= w_k;
            else if (w_adv && w_take) r_rem <= r_rem - 4'd1;
        end
    end
    // a full FIFO blocks the push even when the head is popped in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
        end else begin
            r_wp <= r_wp + AW'(w_adv);
            r_rp <= r_rp + AW'(w_pop);
            r_cnt <= r_cnt + CW'(w_adv) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk) if (w_adv) r_mem[r_wp] <= w_inst;
endmodule

// File: doc/jvm_operand_emitter.md
Name: jvm_operand_emitter

Overview:
- Parametrised successor to the per-byte "load immediate + push" path of the JVM-to-ARM translator.
- Consumes the 0..MAX_BYTES operand bytes that follow a JVM opcode and assembles them big-endian into one ARM register (MOV / LSL / ORR).
- Emits a single push of that register instead of one push per byte.
- Sits between the bytecode fetch unit and the ARM instruction writer; an internal FIFO decouples it from writer back-pressure.

Parameters:
- MAX_BYTES, 4: largest effective operand byte count accepted.
- FIFO_DEPTH, 4: output instruction FIFO entries (power of two, >= 2).
- REG_NUM, 0: ARM register (0..12) used as the assembly register; its 4-bit value is called n below.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin operand sequence; sampled only in IDLE
- op_count  in  3  operand bytes from count ROM
- is_wide  in  1  a "wide" prefix preceded this opcode; doubles op_count
- sign  in  1  sign-extend the result (used only with SIGNEXT_EN)
- in_byte  in  8  operand byte from fetch unit
- in_valid  in  1  in_byte valid
- in_ready  out  1  byte consumed this cycle when in_valid is also high
- inst  out  32  ARM instruction at FIFO head
- inst_valid  out  1  FIFO not empty
- inst_ready  in  1  writer accepts inst
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when the last instruction is queued
- err  out  1  one-cycle pulse when the operand count is illegal

Behaviour:
- Reset: state IDLE, FIFO flushed; in_ready, inst_valid, busy, done, err = 0; inst = 0. Reset mid-sequence aborts the sequence and drops all queued instructions.
- Effective count: k = op_count << is_wide, computed 4 bits wide.
- Start handling, IDLE only:
  - start with k > MAX_BYTES: err pulses the next cycle, nothing is emitted, state stays IDLE.
  - start with k = 0: done pulses the next cycle, nothing is emitted.
  - start outside IDLE is ignored.
- Once a sequence is accepted, busy is high until the cycle after done.
- States and actions:
  - FIRST: take a byte, push MOV Rn,#b = 0xE3A00000 | n<<12 | b. If 1 byte remains, go to PUSH; else go to SHIFT.
  - SHIFT: push MOV Rn,Rn,LSL #8 = 0xE1A00400 | n<<12 | n. Go to MERGE.
  - MERGE: take a byte, push ORR Rn,Rn,#b = 0xE3800000 | n<<16 | n<<12 | b. If the remaining count reaches 0, go to PUSH (or SEXT_L, see Optional Feature); else go to SHIFT.
  - PUSH: push STR Rn,[SP,#-4]! = 0xE52D0004 | n<<12. Assert done. Go to IDLE.
- Stall rules:
  - A state advances only when the FIFO is not full.
  - FIRST and MERGE also require in_valid.
  - in_ready = (state is FIRST or MERGE) and FIFO not full.
- Throughput: at most one instruction per cycle. Without sign extension, a k-byte operand yields exactly 2k instructions.
- FIFO:
  - inst shows the head entry registered; pop on inst_valid & inst_ready.
  - A push is blocked when the FIFO is full, even if a pop happens that cycle.
  - Push into an empty FIFO: inst_valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop when not full: occupancy unchanged, order preserved.
- Bytes are never dropped or duplicated under any stall pattern.

Optional Feature:
- Macro SIGNEXT_EN.
- Defined, and sign=1 latched at start with k in 1..3: after the last MERGE, or after FIRST when k = 1, insert two states before PUSH, with s = 32 - 8k:
  - SEXT_L: push MOV Rn,Rn,LSL #s = 0xE1A00000 | n<<12 | s<<7 | n.
  - SEXT_A: push MOV Rn,Rn,ASR #s = 0xE1A00040 | n<<12 | s<<7 | n.
- Defined, with k = 4 or sign=0: no extra instructions.
- Not defined: the sign port is ignored, the SEXT states do not exist, and the output is always 2k instructions.

Test Plan:
- REG_NUM=0, op_count=1, byte 0x7F, inst_ready=1 -> E3A0007F, E52D0004; done pulses once; busy low afterwards.
- op_count=2, bytes 0x12, 0x34 -> E3A00012, E1A00400, E3800034, E52D0004.
- is_wide=1, op_count=1, bytes 0x01, 0x02 -> E3A00001, E1A00400, E3800002, E52D0004; in_ready low once both bytes are taken.
- FIFO_DEPTH=4, op_count=4, inst_ready held low -> 4 entries queued, then in_ready deasserts with no byte loss. Release inst_ready -> all 8 instructions in order, ending E52D0004.
- is_wide=1, op_count=3 (k=6 > 4) -> err pulses one cycle after start; inst_valid stays 0; a following legal start works normally.
- Reset asserted mid-sequence with 2 entries queued -> next cycle inst_valid=0, busy=0, in_ready=0. With SIGNEXT_EN defined: sign=1, op_count=1, byte 0x80 -> E3A00080, E1A00C00, E1A00C40, E52D0004.
